// File: rtl/encoder_debounce_pkg.sv
// Shared constants for the rotary-encoder input path (this conditioner and the decoder).
package encoder_debounce_pkg;

  localparam logic        ENC_IDLE_LEVEL       = 1'b1;
  localparam int unsigned ENC_DEBOUNCE_DEFAULT = 50000;
  localparam int unsigned ENC_SYNC_DEFAULT     = 2;
  localparam int unsigned ENC_CNT_W_DEFAULT    = 16;

endpackage : encoder_debounce_pkg

// File: rtl/debounce_channel.sv
// One encoder contact: multi-flop synchroniser followed by a stability-count debounce filter.
module debounce_channel
  import encoder_debounce_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = ENC_SYNC_DEFAULT,
  parameter int unsigned STABLE_CYCLES = ENC_DEBOUNCE_DEFAULT,
  parameter int unsigned CNT_W         = ENC_CNT_W_DEFAULT
) (
  input  logic clk,
  input  logic BTN,
  input  logic din,
  output logic dout,
  output logic chg
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       cnt_nxt;
  logic                   q_nxt;
  logic                   chg_nxt;

  // Synchroniser resets to the idle level so the filter sees no change out of reset.
  always_ff @(posedge clk or posedge BTN) begin
    if (BTN) begin
      sync <= {SYNC_STAGES{ENC_IDLE_LEVEL}};
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], din};
    end
  end

  assign s = sync[SYNC_STAGES-1];

  // A differing level must persist STABLE_CYCLES consecutive cycles; any return clears the count.
  always_comb begin
    cnt_nxt = '0;
    q_nxt   = dout;
    chg_nxt = 1'b0;
    if (s != dout) begin
      if (cnt == CNT_MAX) begin
        q_nxt   = s;
        chg_nxt = 1'b1;
      end else begin
        cnt_nxt = cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge BTN) begin
    if (BTN) begin
      cnt  <= '0;
      dout <= ENC_IDLE_LEVEL;
      chg  <= 1'b0;
    end else begin
      cnt  <= cnt_nxt;
      dout <= q_nxt;
      chg  <= chg_nxt;
    end
  end

endmodule : debounce_channel

// File: rtl/encoder_debounce.sv
// Conditions raw quadrature contacts A/B into clean, clk-synchronous levels plus change strobes.
module encoder_debounce
  import encoder_debounce_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = ENC_SYNC_DEFAULT,
  parameter int unsigned STABLE_CYCLES = ENC_DEBOUNCE_DEFAULT,
  parameter int unsigned CNT_W         = ENC_CNT_W_DEFAULT
) (
  input  logic clk,
  input  logic BTN,
  input  logic A_raw,
  input  logic B_raw,
  output logic A,
  output logic B,
  output logic A_chg,
  output logic B_chg
);

  // Parameter legality, caught at elaboration.
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("encoder_debounce: SYNC_STAGES must be >= 2");
  end
  if (STABLE_CYCLES < 1) begin : g_bad_stable
    $error("encoder_debounce: STABLE_CYCLES must be >= 1");
  end
  if (CNT_W < 1 || CNT_W > 31 || (64'(1) << CNT_W) <= 64'(STABLE_CYCLES)) begin : g_bad_cnt_w
    $error("encoder_debounce: CNT_W too small for STABLE_CYCLES");
  end

  debounce_channel #(
    .SYNC_STAGES  (SYNC_STAGES),
    .STABLE_CYCLES(STABLE_CYCLES),
    .CNT_W        (CNT_W)
  ) u_chan_a (
    .clk (clk),
    .BTN (BTN),
    .din (A_raw),
    .dout(A),
    .chg (A_chg)
  );

  debounce_channel #(
    .SYNC_STAGES  (SYNC_STAGES),
    .STABLE_CYCLES(STABLE_CYCLES),
    .CNT_W        (CNT_W)
  ) u_chan_b (
    .clk (clk),
    .BTN (BTN),
    .din (B_raw),
    .dout(B),
    .chg (B_chg)
  );

endmodule : encoder_debounce

// File: tb/tb_encoder_debounce.sv
// Directed bench for encoder_debounce with a short filter (SYNC_STAGES=2, STABLE_CYCLES=4).
module tb_encoder_debounce;

  logic clk = 1'b0;
  logic BTN;
  logic A_raw;
  logic B_raw;
  logic A;
  logic B;
  logic A_chg;
  logic B_chg;

  int n_cmp = 0;
  int n_bad = 0;

  // Activity monitors: strobe counts and a reference quadrature step counter.
  logic     clr = 1'b0;
  int       a_pulses = 0;
  int       b_pulses = 0;
  int       quarters = 0;
  int       backward = 0;
  logic [1:0] prev_ab = 2'b11;

  encoder_debounce #(
    .SYNC_STAGES  (2),
    .STABLE_CYCLES(4),
    .CNT_W        (3)
  ) dut (
    .clk  (clk),
    .BTN  (BTN),
    .A_raw(A_raw),
    .B_raw(B_raw),
    .A    (A),
    .B    (B),
    .A_chg(A_chg),
    .B_chg(B_chg)
  );

  always #5 clk = ~clk;

  // Clockwise order of {A,B}: 11 -> 01 -> 00 -> 10 -> 11.
  function automatic logic [1:0] cw_next(input logic [1:0] ab);
    case (ab)
      2'b11:   cw_next = 2'b01;
      2'b01:   cw_next = 2'b00;
      2'b00:   cw_next = 2'b10;
      default: cw_next = 2'b11;
    endcase
  endfunction

  always @(negedge clk) begin
    if (clr) begin
      a_pulses <= 0;
      b_pulses <= 0;
      quarters <= 0;
      backward <= 0;
    end else begin
      if (A_chg) a_pulses <= a_pulses + 1;
      if (B_chg) b_pulses <= b_pulses + 1;
      if ({A, B} != prev_ab) begin
        if ({A, B} == cw_next(prev_ab)) quarters <= quarters + 1;
        else backward <= backward + 1;
      end
    end
    prev_ab <= {A, B};
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_mon();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  initial begin
    // Reset with contacts low: outputs must be at the idle level before any clock edge.
    BTN   = 1'b1;
    A_raw = 1'b0;
    B_raw = 1'b0;
    #2;
    check_eq("rst_A", 32'(A), 32'd1);
    check_eq("rst_B", 32'(B), 32'd1);
    check_eq("rst_A_chg", 32'(A_chg), 32'd0);
    check_eq("rst_B_chg", 32'(B_chg), 32'd0);
    A_raw = 1'b1;
    B_raw = 1'b1;
    ticks(2);
    BTN = 1'b0;
    ticks(4);
    clear_mon();

    // Clean falling edge on A: A drops on the 6th edge, strobe for that cycle only.
    A_raw = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check_eq($sformatf("clean_A_k%0d", k), 32'(A), (k < 6) ? 32'd1 : 32'd0);
      check_eq($sformatf("clean_Achg_k%0d", k), 32'(A_chg), (k == 6) ? 32'd1 : 32'd0);
    end
    tick();
    check_eq("clean_Achg_after", 32'(A_chg), 32'd0);
    check_eq("clean_A_pulses", 32'(a_pulses), 32'd1);
    check_eq("clean_B_idle", 32'(B), 32'd1);
    A_raw = 1'b1;
    ticks(6);
    check_eq("clean_A_rise", 32'(A), 32'd1);
    ticks(2);
    clear_mon();

    // Bounce on A: low 3, high 1, then low; acceptance 6 edges after final low.
    A_raw = 1'b0;
    ticks(3);
    A_raw = 1'b1;
    tick();
    A_raw = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check_eq($sformatf("bounce_A_k%0d", k), 32'(A), (k < 6) ? 32'd1 : 32'd0);
    end
    tick();
    check_eq("bounce_A_pulses", 32'(a_pulses), 32'd1);
    check_eq("bounce_B", 32'(B), 32'd1);
    check_eq("bounce_B_pulses", 32'(b_pulses), 32'd0);
    A_raw = 1'b1;
    ticks(8);
    clear_mon();

    // Glitch on B: too short to be accepted.
    B_raw = 1'b0;
    ticks(2);
    B_raw = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check_eq($sformatf("glitch_B_k%0d", k), 32'(B), 32'd1);
    end
    check_eq("glitch_B_pulses", 32'(b_pulses), 32'd0);

    // Simultaneous fall on A and B.
    A_raw = 1'b0;
    B_raw = 1'b0;
    ticks(5);
    check_eq("simul_A_k5", 32'(A), 32'd1);
    check_eq("simul_B_k5", 32'(B), 32'd1);
    tick();
    check_eq("simul_A_k6", 32'(A), 32'd0);
    check_eq("simul_B_k6", 32'(B), 32'd0);
    check_eq("simul_Achg", 32'(A_chg), 32'd1);
    check_eq("simul_Bchg", 32'(B_chg), 32'd1);

    // Asynchronous reset while low: outputs return to idle without a clock edge.
    #2;
    BTN = 1'b1;
    #1;
    check_eq("async_rst_A", 32'(A), 32'd1);
    check_eq("async_rst_B", 32'(B), 32'd1);
    A_raw = 1'b1;
    B_raw = 1'b1;
    tick();
    BTN = 1'b0;
    ticks(3);

    // Reset mid-count: progress discarded, full latency again after release.
    A_raw = 1'b0;
    ticks(4);
    BTN = 1'b1;
    tick();
    check_eq("midrst_A_held", 32'(A), 32'd1);
    BTN = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check_eq($sformatf("midrst_A_k%0d", k), 32'(A), (k < 6) ? 32'd1 : 32'd0);
    end
    A_raw = 1'b1;
    ticks(8);
    clear_mon();

    // One clockwise detent at 20-cycle steps.
    A_raw = 1'b0;
    ticks(20);
    B_raw = 1'b0;
    ticks(20);
    A_raw = 1'b1;
    ticks(20);
    B_raw = 1'b1;
    ticks(20);
    check_eq("quad_quarters", 32'(quarters), 32'd4);
    check_eq("quad_detents", 32'(quarters / 4), 32'd1);
    check_eq("quad_backward", 32'(backward), 32'd0);
    check_eq("quad_A_pulses", 32'(a_pulses), 32'd2);
    check_eq("quad_B_pulses", 32'(b_pulses), 32'd2);
    check_eq("quad_A_end", 32'(A), 32'd1);
    check_eq("quad_B_end", 32'(B), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_encoder_debounce
